// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback stage in front of FPU_32: decodes one OP-FP instruction, holds the FPU inputs for the op latency, returns the result.
// Optional feature macro FPU_ISSUE_ILLEGAL_EN: illegal encodings complete with out_illegal=1 instead of being dropped.
module fpu_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int ADD_LAT = 4,
  parameter int DIV_LAT = 30,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op_code,
  input  logic [6:0]       func_code,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic [4:0]       rd_in,
  output logic [2:0]       fpu_mode,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       rd_out,
  output logic             out_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] MODE_MUL  = 3'b000;
  localparam logic [2:0] MODE_ADD  = 3'b001;
  localparam logic [2:0] MODE_SUB  = 3'b010;
  localparam logic [2:0] MODE_DIV  = 3'b011;
  localparam logic [2:0] MODE_IDLE = 3'b111;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             dec_legal;
  logic [2:0]       dec_mode;
  logic [CNT_W-1:0] dec_lat;

  always_comb begin
    dec_legal = 1'b0;
    dec_mode  = MODE_IDLE;
    dec_lat   = '0;
    if (op_code == 7'b1010011) begin
      case (func_code)
        7'b0000000: begin dec_legal = 1'b1; dec_mode = MODE_ADD; dec_lat = CNT_W'(ADD_LAT); end
        7'b0000100: begin dec_legal = 1'b1; dec_mode = MODE_SUB; dec_lat = CNT_W'(ADD_LAT); end
        7'b0001000: begin dec_legal = 1'b1; dec_mode = MODE_MUL; dec_lat = CNT_W'(MUL_LAT); end
        7'b0001100: begin dec_legal = 1'b1; dec_mode = MODE_DIV; dec_lat = CNT_W'(DIV_LAT); end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      fpu_mode    <= MODE_IDLE;
      fpu_a       <= '0;
      fpu_b       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      rd_out      <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_legal) begin
              fpu_mode    <= dec_mode;
              fpu_a       <= rs1_val;
              fpu_b       <= rs2_val;
              rd_out      <= rd_in;
              cnt         <= dec_lat;
              out_illegal <= 1'b0;
              in_ready    <= 1'b0;
              state       <= EXEC;
            end else begin
`ifdef FPU_ISSUE_ILLEGAL_EN
              rd_out      <= rd_in;
              out_result  <= '0;
              out_illegal <= 1'b1;
              out_valid   <= 1'b1;
              in_ready    <= 1'b0;
              state       <= DONE;
`endif
            end
          end
        end
        EXEC: begin
          // FPU inputs stay frozen here; only the counter moves.
          if (cnt == CNT_W'(1)) begin
            out_result <= fpu_result;
            out_valid  <= 1'b1;
            fpu_mode   <= MODE_IDLE;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a behavioural latency-accurate FPU model.
module tb_fpu_issue_ctrl;
  localparam int MUL_LAT = 4;
  localparam int ADD_LAT = 4;
  localparam int DIV_LAT = 30;
  localparam int CNT_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op_code;
  logic [6:0]  func_code;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic [2:0]  fpu_mode;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  rd_out;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;
  int exec_cyc = 0;

  fpu_issue_ctrl #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .func_code(func_code), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_in(rd_in), .fpu_mode(fpu_mode), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .rd_out(rd_out), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // FPU model: result only becomes correct at the edge where the op's latency is reached.
  always @(posedge clk) exec_cyc <= (fpu_mode == 3'b111) ? 0 : exec_cyc + 1;

  function automatic logic [31:0] fpu_val(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m == 3'b001 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (m == 3'b010 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h00000000;
    if (m == 3'b000 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (m == 3'b011 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return 32'hBAD0BAD0;
  endfunction

  function automatic int lat_of(input logic [2:0] m);
    if (m == 3'b000) return MUL_LAT;
    if (m == 3'b011) return DIV_LAT;
    return ADD_LAT;
  endfunction

  always_comb begin
    if (fpu_mode != 3'b111 && exec_cyc >= lat_of(fpu_mode) - 1)
      fpu_result = fpu_val(fpu_mode, fpu_a, fpu_b);
    else
      fpu_result = 32'hDEADBEEF;
  end

  task automatic issue(input logic [6:0] op, input logic [6:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    op_code = op; func_code = fn; rs1_val = a; rs2_val = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid (cyc=-1 on timeout), cycles with fpu_mode==m, cycles with in_ready high.
  task automatic wait_out(input logic [2:0] m, output int cyc, output int mcnt, output int rdy_hi);
    cyc = 0; mcnt = 0; rdy_hi = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (fpu_mode == m) mcnt++;
      if (out_valid) break;
      if (in_ready) rdy_hi++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; func_code = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    #2;
    total++; if (fpu_mode !== 3'b111 || out_valid !== 1'b0 || fpu_a !== 32'h0 || fpu_b !== 32'h0) begin
      bad++; $display("FAIL reset_outputs mode=%b vld=%b a=%h b=%h exp 111/0/0/0", fpu_mode, out_valid, fpu_a, fpu_b); end
    total++; if (out_result !== 32'h0 || rd_out !== 5'd0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL reset_result res=%h rd=%0d ill=%b exp 0/0/0", out_result, rd_out, out_illegal); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    int cyc, mcnt, rdy;
    issue(7'b1010011, 7'b0000000, 32'h3F800000, 32'h40000000, 5'd3);
    wait_out(3'b001, cyc, mcnt, rdy);
    total++; if (cyc != ADD_LAT + 1) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", cyc, ADD_LAT + 1); end
    total++; if (mcnt != ADD_LAT) begin bad++; $display("FAIL add_mode_cycles got=%0d exp=%0d", mcnt, ADD_LAT); end
    total++; if (rdy != 0) begin bad++; $display("FAIL add_in_ready_busy got=%0d cycles high exp=0", rdy); end
    total++; if (out_result !== 32'h40400000 || rd_out !== 5'd3) begin
      bad++; $display("FAIL add_result got=%h rd=%0d exp=40400000 rd=3", out_result, rd_out); end
    total++; if (fpu_mode !== 3'b111) begin bad++; $display("FAIL add_done_mode got=%b exp=111", fpu_mode); end
    accept();
  endtask

  task automatic test_mul_div();
    int cyc, mcnt, rdy;
    issue(7'b1010011, 7'b0001000, 32'h40000000, 32'h40400000, 5'd9);
    wait_out(3'b000, cyc, mcnt, rdy);
    total++; if (cyc != MUL_LAT + 1) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", cyc, MUL_LAT + 1); end
    total++; if (out_result !== 32'h40C00000 || rd_out !== 5'd9) begin
      bad++; $display("FAIL mul_result got=%h rd=%0d exp=40c00000 rd=9", out_result, rd_out); end
    accept();
    issue(7'b1010011, 7'b0001100, 32'h40C00000, 32'h40000000, 5'd31);
    wait_out(3'b011, cyc, mcnt, rdy);
    total++; if (cyc != DIV_LAT + 1 || mcnt != DIV_LAT) begin
      bad++; $display("FAIL div_latency got=%0d mode_cycles=%0d exp=%0d/%0d", cyc, mcnt, DIV_LAT + 1, DIV_LAT); end
    total++; if (out_result !== 32'h40400000 || rd_out !== 5'd31) begin
      bad++; $display("FAIL div_result got=%h rd=%0d exp=40400000 rd=31", out_result, rd_out); end
    accept();
  endtask

  task automatic test_back_pressure();
    int cyc, mcnt, rdy;
    issue(7'b1010011, 7'b0000100, 32'h3F800000, 32'h3F800000, 5'd7);
    wait_out(3'b010, cyc, mcnt, rdy);
    total++; if (cyc != ADD_LAT + 1) begin bad++; $display("FAIL sub_latency got=%0d exp=%0d", cyc, ADD_LAT + 1); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_result !== 32'h0 || rd_out !== 5'd7 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d vld=%b res=%h rd=%0d rdy=%b exp 1/00000000/7/0",
                        i, out_valid, out_result, rd_out, in_ready); end
    end
    accept();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_illegal();
    issue(7'b1010011, 7'b0010000, 32'h3F800000, 32'h40000000, 5'd12);
`ifdef FPU_ISSUE_ILLEGAL_EN
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_illegal !== 1'b1 || rd_out !== 5'd12) begin
      bad++; $display("FAIL illegal_done vld=%b res=%h ill=%b rd=%0d exp 1/0/1/12", out_valid, out_result, out_illegal, rd_out); end
    total++; if (fpu_mode !== 3'b111) begin bad++; $display("FAIL illegal_mode got=%b exp=111", fpu_mode); end
    accept();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL illegal_release rdy=%b exp=1", in_ready); end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || fpu_mode !== 3'b111 || out_illegal !== 1'b0) begin
        bad++; $display("FAIL illegal_drop cyc=%0d vld=%b rdy=%b mode=%b ill=%b exp 0/1/111/0",
                        i, out_valid, in_ready, fpu_mode, out_illegal); end
    end
    issue(7'b0000011, 7'b0000000, 32'h3F800000, 32'h40000000, 5'd4);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_opcode vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
`endif
  endtask

  task automatic test_reset_mid_op();
    int cyc, mcnt, rdy, seen;
    issue(7'b1010011, 7'b0001100, 32'h40C00000, 32'h40000000, 5'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (fpu_mode !== 3'b111 || fpu_a !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_async mode=%b a=%h vld=%b rdy=%b exp 111/0/0/1", fpu_mode, fpu_a, out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < DIV_LAT + 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_result got=%0d valid cycles exp=0", seen); end
    issue(7'b1010011, 7'b0000000, 32'h3F800000, 32'h40000000, 5'd17);
    wait_out(3'b001, cyc, mcnt, rdy);
    total++; if (cyc != ADD_LAT + 1 || out_result !== 32'h40400000 || rd_out !== 5'd17) begin
      bad++; $display("FAIL rst_mid_add lat=%0d res=%h rd=%0d exp %0d/40400000/17", cyc, out_result, rd_out, ADD_LAT + 1); end
    accept();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_div();
    test_back_pressure();
    test_illegal();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
